vga_fb_arbiter: RTL

Arbiter for the single-port framebuffer RAM behind the DE0-CV VGA display. It shares the RAM between the display pixel fetch and a pixel writer, such as a drawing engine or a CPU bridge. The display always wins during the horizontal active fetch window. The writer is served with a request/acknowledge handshake during blanking. It sits between the horizontal/vertical timing FSMs and the RAM, and feeds registered pixel data to the colour output stage.

---
 rtl/vga_fb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// ----------------------------------------------------------------------------
// Shares the single-port framebuffer RAM between the display pixel fetch and
// a pixel writer (drawing engine, CPU bridge, ...). During the horizontal
// fetch window of a visible line the display owns the RAM every cycle. Outside
// that window a waiting writer is served one pixel per cycle with a
// request/acknowledge handshake. Fetched pixels come back one cycle later and
// are presented, registered-strobe qualified, to the colour output stage.
//
// Ports
//   CLK          pixel clock, rising edge
//   RST_N        asynchronous active-low reset
//   HCOUNT       horizontal counter, 0..799
//   V_ACTIVE     current line is a visible line
//   FRAME_START  one-cycle pulse at start of frame, restarts the read address
//   WR_REQ       writer requests one pixel write
//   WR_ADDR      write address, held while WR_REQ=1 and WR_ACK=0
//   WR_DATA      write data, same hold rule
//   WR_ACK       one-cycle pulse: the write is performed this cycle
//   MEM_ADDR     RAM address
//   MEM_WDATA    RAM write data
//   MEM_WE       RAM write enable
//   MEM_RDATA    RAM read data, valid one cycle after the address
//   PIX_DATA     pixel to display, 0 when PIX_VALID=0
//   PIX_VALID    PIX_DATA holds a fetched pixel
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_fb_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int PIXELS      = 307200,
    parameter int FETCH_START = 143,
    parameter int FETCH_LEN   = 640
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [9:0]        HCOUNT,
    input  logic              V_ACTIVE,
    input  logic              FRAME_START,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID
);

    localparam logic [9:0]        WIN_FIRST = 10'(FETCH_START);
    localparam logic [9:0]        WIN_LAST  = 10'(FETCH_START + FETCH_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FETCH,
        FLUSH
    } state_t;

    // state_now is the owner of the RAM in the current cycle; it is decided
    // combinationally so a write can be granted in the very cycle WR_REQ rises.
    // state_reg remembers last cycle's owner for sequencing (FETCH -> FLUSH).
    state_t            state_now;
    state_t            state_reg;

    logic              in_window;
    logic              fetch_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              pix_valid_q;

    assign in_window = V_ACTIVE && (HCOUNT >= WIN_FIRST) && (HCOUNT <= WIN_LAST);

    // FRAME_START overrides the running address, even for a fetch in the
    // same cycle, so the first pixel of a frame always comes from address 0.
    assign fetch_addr = FRAME_START ? '0 : rd_addr;

    // State register: only records who owned the RAM last cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_now;
        end
    end

    // Ownership decision and RAM outputs for the current cycle. The display
    // always wins inside the window; a competing writer simply keeps WR_REQ
    // high and is served on the first cycle outside it. While RST_N is low
    // everything is forced idle so the outputs clear without waiting a clock.
    always_comb begin
        state_now = IDLE;
        WR_ACK    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        fetch_en  = 1'b0;

        if (!RST_N) begin
            state_now = IDLE;
        end else if (in_window) begin
            state_now = FETCH;
        end else if (WR_REQ) begin
            state_now = WRITE;
        end else if (state_reg == FETCH) begin
            state_now = FLUSH;
        end else begin
            state_now = IDLE;
        end

        case (state_now)
            WRITE: begin
                WR_ACK    = 1'b1;
                MEM_WE    = 1'b1;
                MEM_ADDR  = WR_ADDR;
                MEM_WDATA = WR_DATA;
            end
            FETCH: begin
                fetch_en = 1'b1;
                MEM_ADDR = fetch_addr;
            end
            default: begin
            end
        endcase
    end

    // Display read address: advances once per fetch, wraps at the end of the
    // frame buffer and restarts on FRAME_START. It holds on blanking lines.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_addr <= '0;
        end else if (fetch_en) begin
            rd_addr <= (fetch_addr == LAST_ADDR) ? '0 : fetch_addr + ADDR_W'(1);
        end else if (FRAME_START) begin
            rd_addr <= '0;
        end
    end

    // RAM read data arrives one cycle after the address, so the fetch strobe
    // is delayed by one register to mark it. The cycle after the last fetch
    // (FLUSH, or a write) is where the final pixel of the line is shown.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= fetch_en;
        end
    end

    assign PIX_VALID = pix_valid_q;
    assign PIX_DATA  = pix_valid_q ? MEM_RDATA : '0;

endmodule
